// File: rtl/ro_monitor_pkg.sv
// Shared types and default sizing for the ring-oscillator monitor.
package ro_monitor_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SETTLE  = 2'd1,
    ST_MEASURE = 2'd2,
    ST_DONE    = 2'd3
  } ro_state_e;

  localparam int CNT_W_DEF      = 16;
  localparam int WIN_W_DEF      = 12;
  localparam int SETTLE_CYC_DEF = 8;

endpackage

// File: rtl/ro_edge_sync.sv
// Brings an asynchronous tap into the clock domain and flags its rising edges.
module ro_edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic edge_pulse
);

  logic meta_q;
  logic sync_q;
  logic delay_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q  <= 1'b0;
      sync_q  <= 1'b0;
      delay_q <= 1'b0;
    end else begin
      meta_q  <= async_in;
      sync_q  <= meta_q;
      delay_q <= sync_q;
    end
  end

  assign edge_pulse = sync_q & ~delay_q;

endmodule

// File: rtl/ro_monitor_ctrl.sv
// Ring-oscillator measurement controller: enable, settle, count edges over a window, hand off.
// state   | meaning
// IDLE    | ring off, waiting for START
// SETTLE  | ring on, letting it stabilise, edges ignored
// MEASURE | counting synchronised ring edges for win_q cycles
// DONE    | result held with VALID until READY
module ro_monitor_ctrl
  import ro_monitor_pkg::*;
#(
  parameter int CNT_W      = CNT_W_DEF,
  parameter int WIN_W      = WIN_W_DEF,
  parameter int SETTLE_CYC = SETTLE_CYC_DEF
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic [WIN_W-1:0] WINDOW,
  output logic             RO_EN,
  input  logic             RO_OUT,
  output logic             BUSY,
  output logic [CNT_W-1:0] COUNT,
  output logic             OVF,
  output logic             VALID,
  input  logic             READY
);

  localparam int SET_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

  ro_state_e        state;
  logic [WIN_W-1:0] win_q;
  logic [WIN_W-1:0] win_cnt;
  logic [SET_W-1:0] settle_cnt;
  logic [CNT_W-1:0] cnt_q;
  logic             ovf_q;
  logic             ro_edge;

  ro_edge_sync u_edge_sync (
    .clk        (CLK),
    .rst        (RST),
    .async_in   (RO_OUT),
    .edge_pulse (ro_edge)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state      <= ST_IDLE;
      RO_EN      <= 1'b0;
      BUSY       <= 1'b0;
      VALID      <= 1'b0;
      COUNT      <= '0;
      OVF        <= 1'b0;
      win_q      <= '0;
      win_cnt    <= '0;
      settle_cnt <= '0;
      cnt_q      <= '0;
      ovf_q      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (START) begin
            win_q      <= WINDOW;
            cnt_q      <= '0;
            ovf_q      <= 1'b0;
            COUNT      <= '0;
            OVF        <= 1'b0;
            RO_EN      <= 1'b1;
            BUSY       <= 1'b1;
            settle_cnt <= SET_W'(SETTLE_CYC - 1);
            state      <= ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          if (settle_cnt == '0) begin
            if (win_q == '0) begin
              RO_EN <= 1'b0;
              BUSY  <= 1'b0;
              VALID <= 1'b1;
              COUNT <= cnt_q;
              OVF   <= ovf_q;
              state <= ST_DONE;
            end else begin
              win_cnt <= win_q;
              state   <= ST_MEASURE;
            end
          end else begin
            settle_cnt <= settle_cnt - 1'b1;
          end
        end
        ST_MEASURE: begin
          if (win_cnt != '0) begin
            win_cnt <= win_cnt - 1'b1;
            // saturate rather than wrap; the flag stays set for the rest of the window
            if (ro_edge) begin
              if (cnt_q == '1) ovf_q <= 1'b1;
              else             cnt_q <= cnt_q + 1'b1;
            end
          end else begin
            RO_EN <= 1'b0;
            BUSY  <= 1'b0;
            VALID <= 1'b1;
            COUNT <= cnt_q;
            OVF   <= ovf_q;
            state <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (READY) begin
            VALID <= 1'b0;
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
